// File: rtl/enhanced_fifo_logic.sv
// enhanced_fifo_logic
//   Width-converting circular-buffer FIFO. Narrow DBITS-wide symbols are
//   pushed one per cycle. They are delivered as packets of PKT = 2**RD_PKT
//   symbols, and one packet is popped per read.
//
//   Handshake: 'write' is a request that takes effect at a rising edge only
//   while full=0. 'read' is a request that takes effect at a rising edge only
//   while empty=0. A request made while the matching flag is set is silently
//   dropped. dout is show-ahead: it holds the oldest packet whenever
//   empty=0, so the consumer samples dout in the same cycle it raises read.
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (clears pointers, count, storage)
//   write    push din this cycle
//   read     pop one PKT-symbol packet this cycle
//   din      symbol to push
//   empty    fewer than PKT symbols stored
//   full     2**ABITS symbols stored
//   dout     oldest packet, oldest symbol in the low DBITS bits; 0 when empty
module enhanced_fifo_logic #(
  parameter int ABITS  = 3,
  parameter int DBITS  = 2,
  parameter int RD_PKT = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          write,
  input  logic                          read,
  input  logic [DBITS-1:0]              din,
  output logic                          empty,
  output logic                          full,
  output logic [DBITS*(2**RD_PKT)-1:0]  dout
);

  localparam int DEPTH = 2 ** ABITS;
  localparam int PKT   = 2 ** RD_PKT;

  // Count-width constants keep the flag comparisons free of width mixing.
  localparam logic [ABITS:0]   PKT_CNT   = (ABITS+1)'(PKT);
  localparam logic [ABITS:0]   DEPTH_CNT = (ABITS+1)'(DEPTH);
  // When PKT equals the depth this truncates to 0, which is the correct
  // modular step for the read pointer.
  localparam logic [ABITS-1:0] PKT_PTR   = ABITS'(PKT);

  logic [DBITS-1:0] mem_q [DEPTH];
  logic [DBITS-1:0] mem_d [DEPTH];
  logic [ABITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ABITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ABITS:0]   count_q,  count_d;

  logic wr_en;
  logic rd_en;

  // Flags come straight from the registered count. Acceptance therefore
  // always uses the flags from before the edge.
  always_comb begin
    empty = (count_q < PKT_CNT);
    full  = (count_q == DEPTH_CNT);
    wr_en = write && !full;
    rd_en = read && !empty;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PKT_PTR;
    end

    // A simultaneous read needs count >= PKT, so +1-PKT cannot underflow.
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - PKT_CNT;
      2'b11:   count_d = count_q + 1'b1 - PKT_CNT;
      default: count_d = count_q;
    endcase
  end

  // Show-ahead packet assembly. The index arithmetic wraps naturally in
  // ABITS bits, so a packet can straddle the end of storage.
  always_comb begin
    dout = '0;
    if (!empty) begin
      for (int i = 0; i < PKT; i++) begin
        dout[i*DBITS +: DBITS] = mem_q[rd_ptr_q + ABITS'(i)];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_enhanced_fifo_logic.sv
// Testbench for enhanced_fifo_logic. The reference model is a queue of
// symbols. Each accepted read predicts a packet from the model queue and
// pushes it onto exp_q. A separate monitor pops exp_q and compares it
// whenever the DUT presents a packet while read is high.
module tb_enhanced_fifo_logic;

  localparam int ABITS  = 3;
  localparam int DBITS  = 2;
  localparam int RD_PKT = 2;
  localparam int PKT    = 4;
  localparam int DEPTH  = 8;
  localparam int W      = DBITS * PKT;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset_n;
  logic             write;
  logic             read;
  logic [DBITS-1:0] din;
  logic             empty;
  logic             full;
  logic [W-1:0]     dout;

  always #5 clk = ~clk;

  enhanced_fifo_logic #(
    .ABITS (ABITS),
    .DBITS (DBITS),
    .RD_PKT(RD_PKT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .write  (write),
    .read   (read),
    .din    (din),
    .empty  (empty),
    .full   (full),
    .dout   (dout)
  );

  // ---------------- scoreboard state ----------------
  int               tests_run = 0;
  int               fails     = 0;
  logic [DBITS-1:0] model_q[$];
  logic [W-1:0]     exp_q[$];

  task automatic check(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge. The task checks the flags against the
  // model, predicts the effect of the next edge, and then advances one cycle.
  task automatic step(input logic w, input logic r, input logic [DBITS-1:0] d);
    logic [W-1:0] pkt;
    bit           wr_ok;
    bit           rd_ok;
    write = w;
    read  = r;
    din   = d;
    check("empty_flag", W'(empty), W'(model_q.size() < PKT));
    check("full_flag",  W'(full),  W'(model_q.size() == DEPTH));
    wr_ok = w && (model_q.size() < DEPTH);
    rd_ok = r && (model_q.size() >= PKT);
    if (rd_ok) begin
      pkt = '0;
      for (int i = 0; i < PKT; i++) pkt[i*DBITS +: DBITS] = model_q.pop_front();
      exp_q.push_back(pkt);
    end
    if (wr_ok) model_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    write   = 1'bx;
    read    = 1'bx;
    din     = 'x;
    model_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", W'(empty), W'(1));
    check("rst_full",  W'(full),  W'(0));
    check("rst_dout",  dout,      '0);
    reset_n = 1'b1;
    write   = 1'b0;
    read    = 1'b0;
    din     = '0;
    @(posedge clk);
    #1;
    check("rel_empty", W'(empty), W'(1));
    check("rel_dout",  dout,      '0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (empty === 1'b0) begin
        if (read === 1'b1) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            fails++;
            $display("FAIL dout_pkt: got %h with no packet expected at %0t", dout, $time);
          end else begin
            check("dout_pkt", dout, exp_q.pop_front());
          end
        end
      end else begin
        check("dout_when_empty", dout, '0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    write   = 1'bx;
    read    = 1'bx;
    din     = 'x;

    // Reset with X requests.
    do_reset();

    // One full packet: 1,2,3,3 -> 0xF9.
    step(1'b1, 1'b0, 2'd1);
    step(1'b1, 1'b0, 2'd2);
    step(1'b1, 1'b0, 2'd3);
    step(1'b1, 1'b0, 2'd3);
    check("pkt_f9",       dout,      W'(8'hF9));
    check("pkt_f9_empty", W'(empty), W'(0));
    step(1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b0, 2'd0);

    // Fill to full, ignore an extra write, then drain and over-read.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 2'((i + 1) % 4));
    check("full_set", W'(full), W'(1));
    step(1'b1, 1'b0, 2'd2);
    step(1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b0, 2'd0);
    check("drained_dout", dout, '0);

    // Simultaneous write and read with exactly one packet stored.
    do_reset();
    for (int i = 0; i < PKT; i++) step(1'b1, 1'b0, 2'(3 - i));
    step(1'b1, 1'b1, 2'd2);
    step(1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 2'(i));
    step(1'b0, 1'b1, 2'd0);
    step(1'b1, 1'b1, 2'd1);
    step(1'b0, 1'b0, 2'd0);

    // Randomized traffic, including a pass with writes heavily favoured so
    // that the buffer reaches full and wraps repeatedly.
    for (int i = 0; i < 600; i++) begin
      logic w;
      logic r;
      if (i < 300) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 1) != 0);
        r = ($urandom_range(0, 2) == 0);
      end
      step(w, r, 2'($urandom_range(0, 3)));
    end
    step(1'b0, 1'b0, 2'd0);

    // Asynchronous reset in mid-cycle with five symbols stored.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'($urandom_range(0, 3)));
    step(1'b0, 1'b0, 2'd0);
    #2 reset_n = 1'b0;
    #1;
    check("async_empty", W'(empty), W'(1));
    check("async_full",  W'(full),  W'(0));
    check("async_dout",  dout,      '0);
    do_reset();
    step(1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b0, 2'd0);

    if (exp_q.size() != 0) begin
      tests_run++;
      fails++;
      $display("FAIL leftover_packets: got %0d unconsumed, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
